// File: rtl/issueq_int_pkg.sv
// Shared widths, entry record and wakeup helper for the integer issue queue.
package issueq_int_pkg;

  localparam int ISSUEQ_DEPTH = 4;
  localparam int TAG_W        = 6;
  localparam int DATA_W       = 32;
  localparam int OP_W         = 6;
  localparam int CNT_W        = 3;

  localparam logic [OP_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [OP_W-1:0] FUNCT_SUB = 6'h22;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic              rs_valid;
    logic [TAG_W-1:0]  rs_tag;
    logic [DATA_W-1:0] rs_data;
    logic              rt_valid;
    logic [TAG_W-1:0]  rt_tag;
    logic [DATA_W-1:0] rt_data;
    logic [TAG_W-1:0]  rdtag;
  } iq_entry_t;

  typedef enum logic [1:0] {SRC_HOLD, SRC_SHIFT, SRC_LOAD, SRC_EMPTY} iq_src_e;

  // Capture a CDB broadcast into whichever waiting operands match its tag.
  function automatic iq_entry_t iq_wake(input iq_entry_t e, input logic cv,
                                        input logic [TAG_W-1:0] ct,
                                        input logic [DATA_W-1:0] cd);
    iq_entry_t w;
    w = e;
    if (cv && e.valid && !e.rs_valid && (e.rs_tag == ct)) begin
      w.rs_valid = 1'b1;
      w.rs_data  = cd;
    end
    if (cv && e.valid && !e.rt_valid && (e.rt_tag == ct)) begin
      w.rt_valid = 1'b1;
      w.rt_data  = cd;
    end
    return w;
  endfunction

endpackage

// File: rtl/issueq_entry.sv
// One issue-queue slot: source mux (hold/shift/load/empty), CDB wakeup, storage.
module issueq_entry
  import issueq_int_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  iq_src_e           src,
  input  iq_entry_t         shift_in,
  input  iq_entry_t         load_in,
  output iq_entry_t         q
);

  iq_entry_t sel_d;

  always_comb begin
    sel_d = q;
    case (src)
      SRC_HOLD:  sel_d = q;
      SRC_SHIFT: sel_d = shift_in;
      SRC_LOAD:  sel_d = load_in;
      default:   sel_d = '0;
    endcase
  end

  // Wakeup is applied after the mux so shifted and freshly loaded entries also capture.
  always_ff @(posedge clk) begin
    if (reset || flush) q <= '0;
    else                q <= iq_wake(sel_d, cdb_valid, cdb_tag, cdb_data);
  end

endmodule

// File: rtl/issueq_int.sv
// Age-compacted integer issue queue with oldest-ready select and CDB wakeup.
// Optional same-cycle CDB bypass into select: define ISSUEQ_WAKEUP_BYPASS_EN.
module issueq_int
  import issueq_int_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_en,
  input  logic [OP_W-1:0]   dispatch_opcode,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic              dispatch_rsvalid,
  input  logic              dispatch_rtvalid,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  input  logic              issueint_grant,
  output logic              issueint_ready,
  output logic [OP_W-1:0]   issueint_opcode,
  output logic [DATA_W-1:0] issueint_rsdata,
  output logic [DATA_W-1:0] issueint_rtdata,
  output logic [TAG_W-1:0]  issueint_rdtag,
  output logic              issueq_full,
  output logic [CNT_W-1:0]  issueq_count
);

  iq_entry_t               ent  [ISSUEQ_DEPTH];
  iq_entry_t               shin [ISSUEQ_DEPTH];
  iq_src_e                 src  [ISSUEQ_DEPTH];
  iq_entry_t               load_e;
  logic [ISSUEQ_DEPTH-1:0] rdy;
  logic [1:0]              sel_idx;
  logic                    any_rdy;
  logic                    issue_fire;
  logic                    disp_ok;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        wpos;

`ifdef ISSUEQ_WAKEUP_BYPASS_EN
  logic [ISSUEQ_DEPTH-1:0] rs_hit;
  logic [ISSUEQ_DEPTH-1:0] rt_hit;

  always_comb begin
    rs_hit = '0;
    rt_hit = '0;
    rdy    = '0;
    for (int i = 0; i < ISSUEQ_DEPTH; i++) begin
      rs_hit[i] = cdb_valid & ~ent[i].rs_valid & (ent[i].rs_tag == cdb_tag);
      rt_hit[i] = cdb_valid & ~ent[i].rt_valid & (ent[i].rt_tag == cdb_tag);
      rdy[i]    = ent[i].valid & (ent[i].rs_valid | rs_hit[i]) & (ent[i].rt_valid | rt_hit[i]);
    end
  end
`else
  always_comb begin
    rdy = '0;
    for (int i = 0; i < ISSUEQ_DEPTH; i++)
      rdy[i] = ent[i].valid & ent[i].rs_valid & ent[i].rt_valid;
  end
`endif

  always_comb begin
    sel_idx = '0;
    for (int i = ISSUEQ_DEPTH - 1; i >= 0; i--)
      if (rdy[i]) sel_idx = 2'(i);
    any_rdy = |rdy;
  end

  always_comb begin
    issueint_ready  = 1'b0;
    issueint_opcode = '0;
    issueint_rsdata = '0;
    issueint_rtdata = '0;
    issueint_rdtag  = '0;
    if (any_rdy) begin
      issueint_ready  = 1'b1;
      issueint_opcode = ent[sel_idx].opcode;
      issueint_rsdata = ent[sel_idx].rs_data;
      issueint_rtdata = ent[sel_idx].rt_data;
      issueint_rdtag  = ent[sel_idx].rdtag;
`ifdef ISSUEQ_WAKEUP_BYPASS_EN
      if (rs_hit[sel_idx]) issueint_rsdata = cdb_data;
      if (rt_hit[sel_idx]) issueint_rtdata = cdb_data;
`endif
    end
  end

  assign issue_fire  = any_rdy & issueint_grant;
  assign issueq_full = (cnt == CNT_W'(ISSUEQ_DEPTH));
  assign disp_ok     = dispatch_en & ~issueq_full & ~flush;
  // Dispatch lands in the first free slot after this cycle's shift-down.
  assign wpos        = cnt - {{(CNT_W-1){1'b0}}, issue_fire};

  always_comb begin
    load_e          = '0;
    load_e.valid    = 1'b1;
    load_e.opcode   = dispatch_opcode;
    load_e.rs_valid = dispatch_rsvalid;
    load_e.rs_tag   = dispatch_rstag;
    load_e.rs_data  = dispatch_rsdata;
    load_e.rt_valid = dispatch_rtvalid;
    load_e.rt_tag   = dispatch_rttag;
    load_e.rt_data  = dispatch_rtdata;
    load_e.rdtag    = dispatch_rdtag;
  end

  always_comb begin
    for (int i = 0; i < ISSUEQ_DEPTH; i++) begin
      src[i] = SRC_HOLD;
      if (issue_fire && (3'(i) >= {1'b0, sel_idx}))
        src[i] = (i == ISSUEQ_DEPTH - 1) ? SRC_EMPTY : SRC_SHIFT;
      if (disp_ok && (wpos == 3'(i)))
        src[i] = SRC_LOAD;
    end
  end

  for (genvar g = 0; g < ISSUEQ_DEPTH; g++) begin : g_slot
    if (g < ISSUEQ_DEPTH - 1) begin : g_mid
      assign shin[g] = ent[g+1];
    end else begin : g_top
      assign shin[g] = '0;
    end

    issueq_entry u_entry (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .src       (src[g]),
      .shift_in  (shin[g]),
      .load_in   (load_e),
      .q         (ent[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || flush) cnt <= '0;
    else                cnt <= cnt + {{(CNT_W-1){1'b0}}, disp_ok} - {{(CNT_W-1){1'b0}}, issue_fire};
  end

  assign issueq_count = cnt;

endmodule
